// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Pipelined W = 2**N bit shifter: rotate left/right, logical left,
//   arithmetic right. One stage per amt bit, each stage registered, with a
//   bubble-collapsing valid/ready handshake on both sides.
//   Optional build macro PBS_ZERO_FLAG_EN adds a registered 'zero' output.

// One pipeline stage: moves data by 2**K when amt bit K is set.
module pbs_stage #(
  parameter int N = 3,
  parameter int W = 8,
  parameter int K = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ld,        // downstream can take this stage's contents
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  input  logic [N-1:0] in_amt,
  input  logic [1:0]   in_mode,
  output logic         vld_q,
  output logic [W-1:0] data_q,
  output logic [N-1:0] amt_q,
  output logic [1:0]   mode_q,
  output logic [W-1:0] mv_data    // moved data before the register
);
  localparam int D = 2**K;

  logic         vld_d;
  logic [W-1:0] data_d;
  logic [N-1:0] amt_d;
  logic [1:0]   mode_d;

  // Fixed-distance move selected by mode; asr keeps the MSB so chained
  // stages produce a correct sign fill.
  always_comb begin
    mv_data = in_data;
    if (in_amt[K]) begin
      case (in_mode)
        2'b00:   mv_data = (in_data << D) | (in_data >> (W - D));
        2'b01:   mv_data = (in_data >> D) | (in_data << (W - D));
        2'b10:   mv_data = in_data << D;
        default: mv_data = $signed(in_data) >>> D;
      endcase
    end
  end

  // Load on ready; payload only moves with a valid so bubbles keep data.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    amt_d  = amt_q;
    mode_d = mode_q;
    if (ld) begin
      vld_d = in_vld;
      if (in_vld) begin
        data_d = mv_data;
        amt_d  = in_amt;
        mode_d = in_mode;
      end
    end
  end

  // Stage registers, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      amt_q  <= '0;
      mode_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      amt_q  <= amt_d;
      mode_q <= mode_d;
    end
  end
endmodule

module pipelined_barrel_shifter #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] a,
  input  logic [N-1:0]    amt,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2**N-1:0] y
`ifdef PBS_ZERO_FLAG_EN
  ,
  output logic            zero
`endif
);
  localparam int W = 2**N;

  logic [N-1:0]          rdy;
  logic [N-1:0]          vin;
  logic [N-1:0][W-1:0]   din;
  logic [N-1:0][N-1:0]   ain;
  logic [N-1:0][1:0]     min;
  logic [N-1:0]          vld_q;
  logic [N-1:0][W-1:0]   data_q;
  logic [N-1:0][N-1:0]   amt_q;
  logic [N-1:0][1:0]     mode_q;
  logic [N-1:0][W-1:0]   mv;

  for (genvar k = 0; k < N; k++) begin : g_stg
    // Stage k is ready when it or any stage downstream has a hole, or the
    // consumer takes the result (the r[] chain unrolled).
    assign rdy[k] = out_ready | ~(&vld_q[N-1:k]);

    if (k == 0) begin : g_head
      assign vin[k] = in_valid;
      assign din[k] = a;
      assign ain[k] = amt;
      assign min[k] = mode;
    end else begin : g_link
      assign vin[k] = vld_q[k-1];
      assign din[k] = data_q[k-1];
      assign ain[k] = amt_q[k-1];
      assign min[k] = mode_q[k-1];
    end

    pbs_stage #(.N(N), .W(W), .K(k)) u_stg (
      .clk     (clk),
      .reset_n (reset_n),
      .ld      (rdy[k]),
      .in_vld  (vin[k]),
      .in_data (din[k]),
      .in_amt  (ain[k]),
      .in_mode (min[k]),
      .vld_q   (vld_q[k]),
      .data_q  (data_q[k]),
      .amt_q   (amt_q[k]),
      .mode_q  (mode_q[k]),
      .mv_data (mv[k])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_q[N-1];
  assign y         = data_q[N-1];

  // The final stage's amt/mode copies and the intermediate moves have no
  // consumer; fold them here so they are visibly intentional.
  logic unused_tail;
  assign unused_tail = ^{amt_q[N-1], mode_q[N-1], mv};

`ifdef PBS_ZERO_FLAG_EN
  logic zero_d, zero_q;

  // Zero test taken on the final move so it registers alongside y.
  always_comb begin
    zero_d = zero_q;
    if (rdy[N-1] && vin[N-1]) zero_d = ~|mv[N-1];
  end

  // Zero flag register; reset matches y == 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) zero_q <= 1'b1;
    else          zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter (N=3): directed vectors with literal
// expectations plus a per-cycle scoreboard against a plain-arithmetic model.
module tb_pipelined_barrel_shifter;
  localparam int N = 3;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [W-1:0] a = '0;
  logic [W-1:0] y;
  logic [N-1:0] amt = '0;
  logic [1:0]   mode = '0;
`ifdef PBS_ZERO_FLAG_EN
  logic         zero;
`endif

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] y;
    logic         z;
    int           cyc;
  } res_t;

  logic [W-1:0] exp_q[$];
  res_t         got[$];

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .amt       (amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
`ifdef PBS_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: whole-amount shift with wide integer arithmetic.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] x, input int s,
                                             input logic [1:0] m);
    int unsigned v, r, mask;
    v = x;
    mask = (1 << W) - 1;
    case (m)
      2'd0: r = (v << s) | (v >> (W - s));
      2'd1: r = (v >> s) | (v << (W - s));
      2'd2: r = v << s;
      default: begin
        r = v >> s;
        if (x[W-1]) r = r | (mask & ~(mask >> s));
      end
    endcase
    return W'(r & mask);
  endfunction

  // Scoreboard: every cycle out of reset, check ready, data and flag.
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      chk("in_ready", in_ready, (exp_q.size() < N) || out_ready);
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious out_valid", 1, 0);
        else begin
          chk("y vs model", y, exp_q[0]);
`ifdef PBS_ZERO_FLAG_EN
          chk("zero vs model", zero, exp_q[0] == 0);
`endif
        end
      end
      if (out_valid && out_ready && exp_q.size() > 0) begin
        res_t r;
        r.y = y;
        r.cyc = cyc;
`ifdef PBS_ZERO_FLAG_EN
        r.z = zero;
`else
        r.z = 1'b0;
`endif
        void'(exp_q.pop_front());
        got.push_back(r);
      end
      if (in_valid && in_ready) exp_q.push_back(ref_shift(a, int'(amt), mode));
    end
  end

  // Present one operand and hold it until accepted; acc = accept edge.
  task automatic send(input logic [W-1:0] av, input logic [N-1:0] am,
                      input logic [1:0] md, output int acc);
    bit tk = 0;
    int t = 0;
    a = av; amt = am; mode = md; in_valid = 1'b1;
    while (!tk && t < 200) begin
      @(negedge clk);
      tk = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    acc = cyc;
    chk("send accepted", tk, 1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain empties", exp_q.size(), 0);
  endtask

  task automatic wait_got(input int n);
    int t = 0;
    while (got.size() < n && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("result arrives", got.size() >= n, 1);
  endtask

  logic [W-1:0] bp_a[6]  = '{8'h96, 8'h96, 8'h96, 8'h96, 8'h16, 8'hF0};
  logic [N-1:0] bp_s[6]  = '{3'd3, 3'd1, 3'd4, 3'd2, 3'd2, 3'd5};
  logic [1:0]   bp_m[6]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0};
  logic [W-1:0] bp_y[6]  = '{8'hB4, 8'h4B, 8'h60, 8'hE5, 8'h05, 8'h1E};

  initial begin
    int acc, acc2, g0, idx, sent, guard;
    bit tk, hv;
    logic [W-1:0] yh;

    // Reset state.
    #2;
    chk("reset out_valid", out_valid, 0);
    chk("reset y", y, 0);
    chk("reset in_ready", in_ready, 1);
`ifdef PBS_ZERO_FLAG_EN
    chk("reset zero", zero, 1);
`endif
    @(posedge clk); #3 reset_n = 1'b1;
    @(posedge clk); #1;

    // Single op latency: visible after edge acc+N-1.
    out_ready = 1'b1;
    g0 = got.size();
    send(8'h96, 3'd3, 2'd0, acc);
    wait_got(g0 + 1);
    if (got.size() > g0) begin
      chk("rotl 96 by 3", got[g0].y, 8'hB4);
      chk("latency", got[g0].cyc - acc, N - 1);
    end

    // Back-to-back ops emerge on consecutive cycles, in order.
    g0 = got.size();
    send(8'h96, 3'd1, 2'd1, acc);
    send(8'h96, 3'd4, 2'd2, acc);
    send(8'h96, 3'd2, 2'd3, acc);
    send(8'h16, 3'd2, 2'd3, acc);
    drain();
    chk("b2b count", got.size() - g0, 4);
    if (got.size() >= g0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("b2b value", got[g0+i].y, bp_y[i+1]);
        chk("b2b spacing", got[g0+i].cyc - got[g0].cyc, i);
      end
    end

`ifdef PBS_ZERO_FLAG_EN
    // Zero flag.
    g0 = got.size();
    send(8'h01, 3'd7, 2'd2, acc);
    send(8'h80, 3'd1, 2'd2, acc);
    drain();
    if (got.size() >= g0 + 2) begin
      chk("lsl 01 by 7", got[g0].y, 8'h80);
      chk("zero clear", got[g0].z, 0);
      chk("lsl 80 by 1", got[g0+1].y, 8'h00);
      chk("zero set", got[g0+1].z, 1);
    end else chk("zero results", got.size() - g0, 2);
`endif

    // Back-pressure: only N accepts while the consumer stalls.
    g0 = got.size();
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6 && idx < 6; c++) begin
      a = bp_a[idx]; amt = bp_s[idx]; mode = bp_m[idx]; in_valid = 1'b1;
      @(negedge clk);
      tk = in_ready;
      @(posedge clk);
      #1;
      if (tk) idx++;
    end
    in_valid = 1'b0;
    chk("bp accepts", idx, N);
    @(negedge clk);
    yh = y;
    repeat (3) @(negedge clk);
    chk("stall holds y", y, yh);
    chk("stall head", y, 8'hB4);
    chk("stall out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    while (idx < 6) begin
      send(bp_a[idx], bp_s[idx], bp_m[idx], acc);
      idx++;
    end
    drain();
    chk("bp count", got.size() - g0, 6);
    if (got.size() >= g0 + 6)
      for (int i = 0; i < 6; i++) chk("bp order", got[g0+i].y, bp_y[i]);

    // Random handshake traffic, all modes and amounts.
    g0 = got.size();
    sent = 0; guard = 0; hv = 0;
    while (sent < 1000 && guard < 20000) begin
      if (!hv && ($urandom % 4) != 0) begin
        hv = 1;
        a = W'($urandom); amt = N'($urandom); mode = 2'($urandom);
      end
      in_valid = hv;
      out_ready = ($urandom % 3) != 0;
      @(negedge clk);
      tk = hv && in_ready;
      @(posedge clk);
      #1;
      if (tk) begin hv = 0; sent++; end
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("random count", got.size() - g0, 1000);

    // Reset with two ops in flight.
    send(8'h3C, 3'd1, 2'd0, acc);
    send(8'hA5, 3'd2, 2'd1, acc);
    #2 reset_n = 1'b0;
    #1;
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset y", y, 0);
    chk("mid reset in_ready", in_ready, 1);
`ifdef PBS_ZERO_FLAG_EN
    chk("mid reset zero", zero, 1);
`endif
    exp_q.delete();
    @(posedge clk); #3 reset_n = 1'b1;
    g0 = got.size();
    repeat (6) @(posedge clk);
    #1;
    chk("no stale results", got.size() - g0, 0);
    send(8'h0F, 3'd4, 2'd1, acc2);
    wait_got(g0 + 1);
    if (got.size() > g0) begin
      chk("post reset rotr", got[g0].y, 8'hF0);
      chk("post reset latency", got[g0].cyc - acc2, N - 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    errs++;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $fatal(1, "watchdog");
  end
endmodule
